// File: rtl/ctrlu_pkg.sv
// Shared types and encodings for the multi-cycle control unit: state enum,
// opcodes, ALU control codes and datapath mux selects.
package ctrlu_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    TRAP,
    JAL
  } state_t;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_PC4     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_ctrlu_alu_decoder.sv
// Combinational ALU decoder: maps the ALU operation class plus funct3/funct7b5
// to a 3-bit ALU control code and flags encodings the ALU does not support.
module alu_decoder
  import ctrlu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] aluctrl,
  output logic       illegal
);

  // funct7b5 only turns add into sub for register-register operations
  always_comb begin
    aluctrl = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: aluctrl = ALU_ADD;
      ALUOP_SUB: aluctrl = ALU_SUB;
      default: begin
        case (funct3)
          F3_ADD:  aluctrl = (aluop == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_SLT:  aluctrl = ALU_SLT;
          F3_OR:   aluctrl = ALU_OR;
          F3_AND:  aluctrl = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrlu.sv
// Multi-cycle control unit with memory-wait timeout, sticky trap and retired
// instruction counter. Define CTRLU_JAL_EN to add the two-cycle JAL state.
module mc_ctrlu
  import ctrlu_pkg::*;
#(
  parameter int ALU_CTRL_W   = 3,
  parameter int MEM_WAIT_MAX = 15,
  parameter int INSTRET_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  AdrSrc,
  output logic [1:0]            ALUsrcA,
  output logic [1:0]            ALUsrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            ResultSrc,
  output logic [ALU_CTRL_W-1:0] ALUctrl,
  output logic                  trap,
  output logic [INSTRET_W-1:0]  instret
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state;
  state_t            nextState;
  aluop_t            aluop;
  logic [2:0]        aluCtrl3;
  logic              aluIllegal;
  logic [WAIT_W-1:0] waitCnt;
  logic              isWaitState;
  logic              timeout;
  logic              retire;
`ifdef CTRLU_JAL_EN
  logic              jalPhase;
`endif

  alu_decoder u_aludec (
    .aluop   (aluop),
    .funct3  (funct3),
    .funct7b5(funct7b5),
    .aluctrl (aluCtrl3),
    .illegal (aluIllegal)
  );

  assign isWaitState = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign timeout     = !mem_ready && (waitCnt == WAIT_LAST);
  assign trap        = (state == TRAP);

  always_comb begin
    ALUctrl      = '0;
    ALUctrl[2:0] = aluCtrl3;
  end

  always_comb begin
    nextState = state;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    AdrSrc    = 1'b0;
    ALUsrcA   = SRCA_PC;
    ALUsrcB   = SRCB_FOUR;
    ImmSrc    = IMM_I;
    ResultSrc = RES_ALUOUT;
    aluop     = ALUOP_ADD;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nextState = DECODE;
        end else if (timeout) begin
          nextState = TRAP;
        end
      end
      // Branch target is precomputed here so BRANCH only needs the compare
      DECODE: begin
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:          nextState = EXECR;
          OP_ITYPE:          nextState = EXECI;
          OP_BRANCH:         nextState = BRANCH;
`ifdef CTRLU_JAL_EN
          OP_JAL:            nextState = JAL;
`endif
          default:           nextState = TRAP;
        endcase
      end
      MEMADR: begin
        ALUsrcA   = SRCA_RS1;
        ALUsrcB   = SRCB_IMM;
        ImmSrc    = (op == OP_STORE) ? IMM_S : IMM_I;
        nextState = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready)    nextState = MEMWB;
        else if (timeout) nextState = TRAP;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_MEMDATA;
        retire    = 1'b1;
        nextState = FETCH;
      end
      MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nextState = FETCH;
        end else if (timeout) begin
          nextState = TRAP;
        end
      end
      EXECR: begin
        ALUsrcA   = SRCA_RS1;
        ALUsrcB   = SRCB_RS2;
        aluop     = ALUOP_RTYPE;
        nextState = aluIllegal ? TRAP : ALUWB;
      end
      EXECI: begin
        ALUsrcA   = SRCA_RS1;
        ALUsrcB   = SRCB_IMM;
        ImmSrc    = IMM_I;
        aluop     = ALUOP_ITYPE;
        nextState = aluIllegal ? TRAP : ALUWB;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_ALUOUT;
        retire    = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        ALUsrcA   = SRCA_RS1;
        ALUsrcB   = SRCB_RS2;
        ImmSrc    = IMM_B;
        aluop     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        case (funct3)
          F3_BEQ: begin
            PCWrite   = EQ;
            retire    = 1'b1;
            nextState = FETCH;
          end
          F3_BNE: begin
            PCWrite   = !EQ;
            retire    = 1'b1;
            nextState = FETCH;
          end
          default: nextState = TRAP;
        endcase
      end
`ifdef CTRLU_JAL_EN
      // First JAL cycle forms PC_old+imm, second commits PC and link register
      JAL: begin
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_IMM;
        ImmSrc  = IMM_J;
        if (jalPhase) begin
          PCWrite   = 1'b1;
          RegWrite  = 1'b1;
          ResultSrc = RES_PC4;
          retire    = 1'b1;
          nextState = FETCH;
        end
      end
`endif
      TRAP:    nextState = TRAP;
      default: nextState = TRAP;
    endcase
    // The reset cycle must never write architectural state
    if (rst) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      waitCnt <= '0;
      instret <= '0;
    end else begin
      state   <= nextState;
      instret <= instret + INSTRET_W'(retire);
      if (nextState != state)
        waitCnt <= '0;
      else if (isWaitState && !mem_ready)
        waitCnt <= waitCnt + 1'b1;
    end
  end

`ifdef CTRLU_JAL_EN
  always_ff @(posedge clk) begin
    if (rst) jalPhase <= 1'b0;
    else     jalPhase <= (state == JAL) && !jalPhase;
  end
`endif

endmodule

// File: tb/tb_mc_ctrlu.sv
// Self-checking bench for mc_ctrlu: table of single instructions plus
// hand-written sequences for memory stalls, timeout trap and mid-access reset.
module tb_mc_ctrlu;

  localparam int WAITMAX = 15;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       EQ;
  logic       mem_ready;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, MemRead, AdrSrc;
  logic [1:0] ALUsrcA, ALUsrcB, ImmSrc, ResultSrc;
  logic [3:0] ALUctrl;
  logic       trap;
  logic [3:0] instret;

  int nCompared = 0;
  int nMismatch = 0;
  logic [3:0] expInstret;

  mc_ctrlu #(.ALU_CTRL_W(4), .MEM_WAIT_MAX(WAITMAX), .INSTRET_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .EQ(EQ), .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead), .AdrSrc(AdrSrc),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .ALUctrl(ALUctrl), .trap(trap), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       eq;
    int         expLen;
    logic       expTrap;
    int         expRegW;
    int         expMemW;
    int         expPcW;
    logic       chkAlu;
    logic [3:0] expAlu;
    int         expRet;
  } vec_t;

  vec_t vecs[21];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f, input logic f7,
                               input logic e, input logic rdy);
    op        = o;
    funct3    = f;
    funct7b5  = f7;
    EQ        = e;
    mem_ready = rdy;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench inside the first FETCH cycle after reset
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst.strobes", 32'({RegWrite, MemWrite, PCWrite}), 32'd0);
    nextCycle();
    rst = 1'b0;
    #1;
    expInstret = '0;
  endtask

  // Runs one instruction from the current FETCH cycle with mem_ready=1
  task automatic runInstr(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic e,
                          output int len, output logic trapSeen, output int regW,
                          output int memW, output int pcW, output logic [3:0] alu3);
    applyStimulus(o, f, f7, e, 1'b1);
    #1;
    len = -1; trapSeen = 1'b0; regW = 0; memW = 0; pcW = 0; alu3 = '0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) nextCycle();
      if (c == 3) alu3 = ALUctrl;
      if (trap) begin
        trapSeen = 1'b1;
        len = c;
        break;
      end
      if (c > 1 && MemRead && !AdrSrc) begin
        len = c - 1;
        break;
      end
      if (c > 1) begin
        regW += int'(RegWrite);
        memW += int'(MemWrite);
        pcW  += int'(PCWrite);
      end
    end
  endtask

  initial begin
    int len, regW, memW, pcW, rdCycles, sawMemW, wb, irw;
    logic trapSeen;
    logic [3:0] alu3;

    rst = 1'b1;
    applyStimulus(7'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    expInstret = '0;

    vecs[0]  = '{7'b0010011, 3'b000, 1'b0, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0000, 1};
    vecs[1]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0000, 1};
    vecs[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0000, 1};
    vecs[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0001, 1};
    vecs[4]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0010, 1};
    vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0011, 1};
    vecs[6]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0101, 1};
    vecs[7]  = '{7'b0010011, 3'b111, 1'b0, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0010, 1};
    vecs[8]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0011, 1};
    vecs[9]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4, 1'b0, 1, 0, 0, 1'b1, 4'b0101, 1};
    vecs[10] = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 1'b0, 1, 0, 0, 1'b1, 4'b0000, 1};
    vecs[11] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 1'b0, 0, 1, 0, 1'b1, 4'b0000, 1};
    vecs[12] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 1'b0, 0, 0, 1, 1'b1, 4'b0001, 1};
    vecs[13] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 1'b0, 0, 0, 0, 1'b1, 4'b0001, 1};
    vecs[14] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 3, 1'b0, 0, 0, 1, 1'b1, 4'b0001, 1};
    vecs[15] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 3, 1'b0, 0, 0, 0, 1'b1, 4'b0001, 1};
    vecs[16] = '{7'b0110011, 3'b001, 1'b0, 1'b0, 4, 1'b1, 0, 0, 0, 1'b0, 4'b0000, 0};
    vecs[17] = '{7'b0010011, 3'b100, 1'b0, 1'b0, 4, 1'b1, 0, 0, 0, 1'b0, 4'b0000, 0};
    vecs[18] = '{7'b1100011, 3'b100, 1'b0, 1'b0, 4, 1'b1, 0, 0, 0, 1'b0, 4'b0000, 0};
`ifdef CTRLU_JAL_EN
    vecs[19] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 1'b0, 1, 0, 1, 1'b0, 4'b0000, 1};
`else
    vecs[19] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 3, 1'b1, 0, 0, 0, 1'b0, 4'b0000, 0};
`endif
    vecs[20] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 3, 1'b1, 0, 0, 0, 1'b0, 4'b0000, 0};

    // Reset state
    @(posedge clk);
    nextCycle();
    checkOutput("rst.strobes", 32'({RegWrite, MemWrite, PCWrite}), 32'd0);
    checkOutput("rst.trap", 32'(trap), 32'd0);
    checkOutput("rst.instret", 32'(instret), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst.fetch", 32'({MemRead, AdrSrc}), 32'b10);

    $display("[TB] table-driven instructions");
    for (int i = 0; i < 21; i++) begin
      runInstr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].eq, len, trapSeen, regW, memW, pcW, alu3);
      expInstret = expInstret + 4'(vecs[i].expRet);
      checkOutput($sformatf("v%0d.len", i), 32'(len), 32'(vecs[i].expLen));
      checkOutput($sformatf("v%0d.trap", i), 32'(trapSeen), 32'(vecs[i].expTrap));
      checkOutput($sformatf("v%0d.regw", i), 32'(regW), 32'(vecs[i].expRegW));
      checkOutput($sformatf("v%0d.memw", i), 32'(memW), 32'(vecs[i].expMemW));
      checkOutput($sformatf("v%0d.pcw", i), 32'(pcW), 32'(vecs[i].expPcW));
      if (vecs[i].chkAlu)
        checkOutput($sformatf("v%0d.alu", i), 32'(alu3), 32'(vecs[i].expAlu));
      checkOutput($sformatf("v%0d.instret", i), 32'(instret), 32'(expInstret));
      if (trapSeen) begin
        checkOutput($sformatf("v%0d.trapstrobes", i),
                    32'({IRWrite, PCWrite, RegWrite, MemWrite, MemRead}), 32'd0);
        doReset();
        checkOutput($sformatf("v%0d.trapclr", i), 32'(trap), 32'd0);
      end
    end

    $display("[TB] lw with three stalled MEMREAD cycles");
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    #1;
    rdCycles = 0; sawMemW = 0; wb = 0; len = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) nextCycle();
      if (MemWrite) sawMemW++;
      if (MemRead && AdrSrc) begin
        rdCycles++;
        mem_ready = (rdCycles > 3);
      end else if (rdCycles > 0 && RegWrite && ResultSrc == 2'b01) begin
        wb++;
      end
      if (c > 1 && MemRead && !AdrSrc) begin
        len = c - 1;
        break;
      end
    end
    expInstret = expInstret + 4'd1;
    checkOutput("lwstall.rdcycles", 32'(rdCycles), 32'd4);
    checkOutput("lwstall.memwrite", 32'(sawMemW), 32'd0);
    checkOutput("lwstall.memwb", 32'(wb), 32'd1);
    checkOutput("lwstall.len", 32'(len), 32'd8);
    checkOutput("lwstall.instret", 32'(instret), 32'(expInstret));

    $display("[TB] FETCH stall one cycle short of the limit");
    applyStimulus(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    irw = int'(IRWrite);
    for (int c = 2; c <= WAITMAX - 1; c++) begin
      nextCycle();
      irw += int'(IRWrite) + int'(trap);
    end
    @(negedge clk);
    runInstr(7'b0010011, 3'b000, 1'b0, 1'b0, len, trapSeen, regW, memW, pcW, alu3);
    expInstret = expInstret + 4'd1;
    checkOutput("nearmax.irw", 32'(irw), 32'd0);
    checkOutput("nearmax.trap", 32'(trapSeen), 32'd0);
    checkOutput("nearmax.len", 32'(len), 32'd4);
    checkOutput("nearmax.instret", 32'(instret), 32'(expInstret));

    $display("[TB] FETCH timeout");
    mem_ready = 1'b0;
    #1;
    for (int c = 2; c <= WAITMAX; c++) nextCycle();
    checkOutput("timeout.before", 32'(trap), 32'd0);
    nextCycle();
    checkOutput("timeout.trap", 32'(trap), 32'd1);
    mem_ready = 1'b1;
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("timeout.sticky", 32'(trap), 32'd1);
    checkOutput("timeout.strobes", 32'({IRWrite, PCWrite, RegWrite, MemWrite, MemRead}), 32'd0);
    checkOutput("timeout.instret", 32'(instret), 32'(expInstret));
    doReset();
    checkOutput("timeout.clear", 32'(trap), 32'd0);

    $display("[TB] reset during MEMWRITE");
    runInstr(7'b0010011, 3'b000, 1'b0, 1'b0, len, trapSeen, regW, memW, pcW, alu3);
    expInstret = expInstret + 4'd1;
    checkOutput("rstmw.pre_instret", 32'(instret), 32'(expInstret));
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    #1;
    nextCycle();
    nextCycle();
    mem_ready = 1'b0;
    nextCycle();
    checkOutput("rstmw.memwrite", 32'({MemWrite, AdrSrc}), 32'b11);
    rst = 1'b1;
    #1;
    checkOutput("rstmw.gated", 32'(MemWrite), 32'd0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("rstmw.fetch", 32'({MemRead, AdrSrc, MemWrite}), 32'b100);
    checkOutput("rstmw.instret", 32'(instret), 32'd0);
    checkOutput("rstmw.trap", 32'(trap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
